// File: rtl/dataload_pkg.sv
// dataload_pkg: shared definitions for the packed data loader.
//   load_type_t  - tag carried with each loaded word
//   LOAD_WEIGHT  - word goes to the weight FIFO
//   LOAD_INPUT   - word goes to the packed input banks
//   DATA_W_DEFAULT - default loaded word width
package dataload_pkg;

    typedef logic load_type_t;

    localparam load_type_t  LOAD_WEIGHT    = 1'b0;
    localparam load_type_t  LOAD_INPUT     = 1'b1;
    localparam int unsigned DATA_W_DEFAULT = 32;

endpackage

// File: rtl/dataload_wfifo.sv
// dataload_wfifo: first-word-fall-through weight FIFO.
//   clk, rst     - clock, asynchronous active-high reset
//   flush        - synchronous clear (pointers and count), wins over push/pop
//   push         - write push_data (ignored when full)
//   push_data    - word to write
//   pop          - consumer takes head (ignored when empty)
//   head         - current head word, 0 while empty
//   valid        - FIFO not empty
//   count        - number of stored words
module dataload_wfifo
    import dataload_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned W_DEPTH = 8,
    localparam int unsigned CW     = $clog2(W_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic [CW-1:0]     count
);

    localparam int unsigned PW = $clog2(W_DEPTH);

    logic [DATA_W-1:0] mem [W_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign valid   = (count != '0);
    assign do_push = push && (count != CW'(W_DEPTH)) && !flush;
    assign do_pop  = pop && valid && !flush;
    assign head    = valid ? mem[rd_ptr] : '0;

    // Storage needs no reset: head is masked to 0 whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dataload_pp.sv
// dataload_pp: packs tagged input words into IN_WORDS-wide vectors held in
// two ping-pong banks and buffers weight words in a FIFO. Both outputs are
// valid/ready so the PE array can stall without data loss.
//   clk, rst        - clock, asynchronous active-high reset
//   flush_i         - sync clear of partial frame, both banks, weight FIFO
//   data_i          - loaded word
//   load_en_i       - word present on data_i
//   load_type       - LOAD_WEIGHT / LOAD_INPUT
//   load_ready_o    - word accepted when load_en_i & load_ready_o
//   input_data_o    - packed vector, word k at [k*DATA_W +: DATA_W]
//   input_valid_o   - input_data_o holds a complete vector
//   input_ready_i   - consumer takes vector
//   weight_o        - weight FIFO head, 0 when empty
//   weight_valid_o  - weight FIFO not empty
//   weight_ready_i  - consumer pops weight head
//   fill_cnt_o      - words in the partial input frame
// Build option DATALOAD_STAT_EN adds stat_frames_o / stat_wwords_o:
// saturating counts of completed vectors and accepted weight words,
// cleared by rst only.
module dataload_pp
    import dataload_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned IN_WORDS = 8,
    parameter int unsigned W_DEPTH  = 8,
    localparam int unsigned FW      = $clog2(IN_WORDS + 1),
    localparam int unsigned VW      = IN_WORDS * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              load_en_i,
    input  logic              load_type,
    output logic              load_ready_o,
    output logic [VW-1:0]     input_data_o,
    output logic              input_valid_o,
    input  logic              input_ready_i,
    output logic [DATA_W-1:0] weight_o,
    output logic              weight_valid_o,
    input  logic              weight_ready_i,
    output logic [FW-1:0]     fill_cnt_o
`ifdef DATALOAD_STAT_EN
    ,
    output logic [15:0]       stat_frames_o,
    output logic [15:0]       stat_wwords_o
`endif
);

    localparam int unsigned CW = $clog2(W_DEPTH + 1);

    logic [VW-1:0] bank [2];
    logic [1:0]    bank_full;
    logic [1:0]    bank_full_nxt;
    logic          wr_bank;
    logic          rd_bank;
    logic [FW-1:0] fill_cnt;
    logic [CW-1:0] w_count;
    logic          is_input;
    logic          in_accept;
    logic          in_last;
    logic          in_take;
    logic          w_push;

    assign is_input     = (load_type == LOAD_INPUT);
    assign load_ready_o = is_input ? !bank_full[wr_bank] : (w_count < CW'(W_DEPTH));

    assign in_accept = load_en_i && load_ready_o && is_input && !flush_i;
    assign in_last   = (fill_cnt == FW'(IN_WORDS - 1));
    assign in_take   = input_valid_o && input_ready_i && !flush_i;
    assign w_push    = load_en_i && load_ready_o && !is_input && !flush_i;

    assign input_valid_o = bank_full[rd_bank];
    assign input_data_o  = bank[rd_bank];
    assign fill_cnt_o    = fill_cnt;

    // Draining rd_bank and completing wr_bank in the same cycle touch
    // different banks (wr_bank can't be full while accepting), so both apply.
    always_comb begin
        bank_full_nxt = bank_full;
        if (in_take) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
        if (in_accept && in_last) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank[0]   <= '0;
            bank[1]   <= '0;
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            fill_cnt  <= '0;
        end else if (flush_i) begin
            bank[0]   <= '0;
            bank[1]   <= '0;
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            fill_cnt  <= '0;
        end else begin
            bank_full <= bank_full_nxt;
            if (in_take) begin
                rd_bank <= !rd_bank;
            end
            if (in_accept) begin
                for (int unsigned k = 0; k < IN_WORDS; k++) begin
                    if (fill_cnt == FW'(k)) begin
                        bank[wr_bank][k*DATA_W +: DATA_W] <= data_i;
                    end
                end
                if (in_last) begin
                    fill_cnt <= '0;
                    wr_bank  <= !wr_bank;
                end else begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
        end
    end

    dataload_wfifo #(
        .DATA_W  (DATA_W),
        .W_DEPTH (W_DEPTH)
    ) u_wfifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_i),
        .push      (w_push),
        .push_data (data_i),
        .pop       (weight_ready_i),
        .head      (weight_o),
        .valid     (weight_valid_o),
        .count     (w_count)
    );

`ifdef DATALOAD_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_frames_o <= '0;
            stat_wwords_o <= '0;
        end else begin
            if (in_accept && in_last && (stat_frames_o != '1)) begin
                stat_frames_o <= stat_frames_o + 1'b1;
            end
            if (w_push && (stat_wwords_o != '1)) begin
                stat_wwords_o <= stat_wwords_o + 1'b1;
            end
        end
    end
`endif

endmodule
